// File: rtl/rr_arb_8.sv
// rr_arb_8: 8-way round-robin arbiter with per-owner hold limit.
// A grant is held until the owner strobes done, drops its request, or
// uses up MAX_HOLD cycles. One idle turnaround cycle always separates
// consecutive grants. All outputs are registered.
module rr_arb_8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [3:0] r_hold_cnt;

  logic [2:0] w_sel;
  logic       w_any;
  logic       w_release;

  // Pick the first requester at or after the priority pointer, wrapping 7->0.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!w_any && req[r_ptr + 3'(i)]) begin
        w_any = 1'b1;
        w_sel = r_ptr + 3'(i);
      end
    end
  end

  // Any one of these ends the current grant; overlapping causes behave as one.
  always_comb begin
    w_release = done || !req[gnt_idx] || (r_hold_cnt == HOLD_LAST);
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      gnt        <= '0;
      gnt_idx    <= '0;
      gnt_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            gnt        <= 8'd1 << w_sel;
            gnt_idx    <= w_sel;
            gnt_valid  <= 1'b1;
            r_hold_cnt <= '0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (w_release) begin
            gnt        <= '0;
            gnt_valid  <= 1'b0;
            r_ptr      <= gnt_idx + 3'd1;
            r_hold_cnt <= '0;
            r_state    <= IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_8.sv
// tb_rr_arb_8: table-driven, scoreboard-checked bench for rr_arb_8.
module tb_rr_arb_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req, req1;
  logic       done, done1;
  logic [7:0] gnt, gnt1;
  logic [2:0] gnt_idx, gnt_idx1;
  logic       gnt_valid, gnt_valid1;

  int unsigned checks;
  int unsigned failures;

  rr_arb_8 #(.MAX_HOLD(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  rr_arb_8 #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .done(done1),
    .gnt(gnt1), .gnt_idx(gnt_idx1), .gnt_valid(gnt_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pre_rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] e_gnt;
    logic [2:0] e_idx;
    logic       e_v;
    string      name;
  } vec_t;

  typedef struct {
    string      name;
    logic       which;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       v;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(logic pr, logic [7:0] r, logic d,
                              logic [7:0] eg, logic [2:0] ei, logic ev, string nm);
    vec_t t;
    t.pre_rst = pr; t.req = r; t.done = d;
    t.e_gnt = eg; t.e_idx = ei; t.e_v = ev; t.name = nm;
    return t;
  endfunction

  task automatic push(string nm, logic which, logic [7:0] g, logic [2:0] i, logic v);
    exp_t e;
    e.name = nm; e.which = which; e.gnt = g; e.idx = i; e.v = v;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [7:0] ag;
    logic [2:0] ai;
    logic       av;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty: got no expected entry, required one");
      return;
    end
    e  = sb.pop_front();
    ag = e.which ? gnt1 : gnt;
    ai = e.which ? gnt_idx1 : gnt_idx;
    av = e.which ? gnt_valid1 : gnt_valid;
    checks++;
    if (ag !== e.gnt || ai !== e.idx || av !== e.v) begin
      failures++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b, required gnt=%h idx=%0d valid=%b",
               e.name, ag, ai, av, e.gnt, e.idx, e.v);
    end
    checks++;
    if ($countones(ag) > 1) begin
      failures++;
      $display("FAIL %s_onehot: got gnt=%h, required at most one bit set", e.name, ag);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Idle noise straight out of reset: done toggling with no requests.
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 8'h00, 1, 8'h00, 3'd0, 0, "idle_noise"));
    // Single requester 2, MAX_HOLD=4: 4 grant cycles, 1 idle, regrant.
    tbl.push_back(mk(0, 8'h04, 0, 8'h04, 3'd2, 1, "single_g0"));
    tbl.push_back(mk(0, 8'h04, 0, 8'h04, 3'd2, 1, "single_g1"));
    tbl.push_back(mk(0, 8'h04, 0, 8'h04, 3'd2, 1, "single_g2"));
    tbl.push_back(mk(0, 8'h04, 0, 8'h04, 3'd2, 1, "single_g3"));
    tbl.push_back(mk(0, 8'h04, 0, 8'h00, 3'd2, 0, "single_timeout"));
    tbl.push_back(mk(0, 8'h04, 0, 8'h04, 3'd2, 1, "single_regrant"));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 3'd2, 0, "single_drop"));
    // Rotation 0..7,0 with done on each grant's first cycle.
    for (int k = 0; k < 9; k++) begin
      tbl.push_back(mk(k == 0, 8'hFF, 0, 8'd1 << (k % 8), 3'(k % 8), 1, "rot_grant"));
      tbl.push_back(mk(0, 8'hFF, 1, 8'h00, 3'(k % 8), 0, "rot_release"));
    end
    // Wrap-around: grant 5, then ptr=6 with req=03 selects 0, then ptr=1.
    tbl.push_back(mk(1, 8'h20, 0, 8'h20, 3'd5, 1, "wrap_g5"));
    tbl.push_back(mk(0, 8'h20, 1, 8'h00, 3'd5, 0, "wrap_r5"));
    tbl.push_back(mk(0, 8'h03, 0, 8'h01, 3'd0, 1, "wrap_g0"));
    tbl.push_back(mk(0, 8'h03, 1, 8'h00, 3'd0, 0, "wrap_r0"));
    tbl.push_back(mk(0, 8'h03, 0, 8'h02, 3'd1, 1, "wrap_g1_ptr1"));
    tbl.push_back(mk(0, 8'h03, 1, 8'h00, 3'd1, 0, "wrap_r1"));
    // Owner 3 drops its request on the 2nd grant cycle; others request meanwhile.
    tbl.push_back(mk(0, 8'h08, 0, 8'h08, 3'd3, 1, "drop_g3"));
    tbl.push_back(mk(0, 8'hFF, 0, 8'h08, 3'd3, 1, "drop_nonowner"));
    tbl.push_back(mk(0, 8'hF7, 0, 8'h00, 3'd3, 0, "drop_release"));
    tbl.push_back(mk(0, 8'h18, 0, 8'h10, 3'd4, 1, "drop_ptr4"));
    tbl.push_back(mk(0, 8'h18, 1, 8'h00, 3'd4, 0, "drop_r4"));
    // done coinciding with timeout; done in IDLE ignored.
    tbl.push_back(mk(0, 8'h20, 0, 8'h20, 3'd5, 1, "sim_g0"));
    tbl.push_back(mk(0, 8'h20, 0, 8'h20, 3'd5, 1, "sim_g1"));
    tbl.push_back(mk(0, 8'h20, 0, 8'h20, 3'd5, 1, "sim_g2"));
    tbl.push_back(mk(0, 8'h20, 0, 8'h20, 3'd5, 1, "sim_g3"));
    tbl.push_back(mk(0, 8'h20, 1, 8'h00, 3'd5, 0, "sim_release"));
    tbl.push_back(mk(0, 8'h20, 0, 8'h20, 3'd5, 1, "sim_regrant"));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 3'd5, 0, "sim_drop"));
    tbl.push_back(mk(0, 8'h00, 1, 8'h00, 3'd5, 0, "idle_done"));

    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    req1  = '0;
    done1 = 1'b0;
    #2;
    push("reset_dut", 0, 8'h00, 3'd0, 0);
    check_out();
    push("reset_dut1", 1, 8'h00, 3'd0, 0);
    check_out();
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[n]) begin
      if (tbl[n].pre_rst) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      req  = tbl[n].req;
      done = tbl[n].done;
      push(tbl[n].name, 0, tbl[n].e_gnt, tbl[n].e_idx, tbl[n].e_v);
      @(posedge clk);
      #1;
      check_out();
    end

    // Async reset mid-grant of requester 7, then restart from requester 0.
    done  = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req = 8'h80;
    push("areset_g7", 0, 8'h80, 3'd7, 1);
    @(posedge clk);
    #1;
    check_out();
    #2 rst_n = 1'b0;
    push("areset_immediate", 0, 8'h00, 3'd0, 0);
    #1 check_out();
    #2 rst_n = 1'b1;
    req = 8'h81;
    push("areset_restart_g0", 0, 8'h01, 3'd0, 1);
    @(posedge clk);
    #1;
    check_out();
    done = 1'b1;
    push("areset_release", 0, 8'h00, 3'd0, 0);
    @(posedge clk);
    #1;
    check_out();
    done = 1'b0;
    req  = 8'h00;

    // MAX_HOLD=1: every grant lasts one cycle, then one idle cycle.
    req1 = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push("hold1_grant", 1, 8'd1 << (k / 2), 3'(k / 2), 1);
      else            push("hold1_release", 1, 8'h00, 3'(k / 2), 0);
      @(posedge clk);
      #1;
      check_out();
    end
    req1 = 8'h00;

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_leftover: got %0d entries, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb_8.md
RR_ARB_8 -- requirements
Module: rr_arb_8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive grant cycles per owner (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 8 bits, one request bit per requester 0..7.
REQ-005 The block SHALL have port done, input, 1 bit, a release strobe from the current owner.
REQ-006 The block SHALL have port gnt, output, 8 bits, the one-hot grant vector.
REQ-007 The block SHALL have port gnt_idx, output, 3 bits, the binary index of the current or last owner.
REQ-008 The block SHALL have port gnt_valid, output, 1 bit, high while a grant is active.

Function
REQ-009 The block SHALL implement two states, IDLE and BUSY, with all outputs registered.
REQ-010 gnt SHALL equal the 3-to-8 one-hot decode of gnt_idx when gnt_valid=1, and SHALL be 8'h00 when gnt_valid=0.
REQ-011 gnt SHALL never have more than one bit set.
REQ-012 The block SHALL hold a 3-bit priority pointer ptr marking the highest-priority requester.
REQ-013 In IDLE with req!=0, the block SHALL select the first set req bit scanning ptr, ptr+1, ... modulo 8 (wrapping 7->0).
- On that edge: gnt_idx <= selection, gnt_valid <= 1, hold_cnt <= 0, state <= BUSY.
REQ-014 In IDLE with req==0, all outputs SHALL hold (gnt_valid=0; gnt_idx keeps its last value).
REQ-015 Grant latency SHALL be one cycle: a req sampled at edge N in IDLE produces gnt after edge N.
REQ-016 In BUSY, the block SHALL release on the edge where any of the following holds:
- done=1; or
- req[gnt_idx]=0; or
- hold_cnt==MAX_HOLD-1.
REQ-017 Otherwise, in BUSY the block SHALL increment hold_cnt and keep gnt unchanged.
REQ-018 On release: gnt_valid <= 0, state <= IDLE, ptr <= gnt_idx+1 (mod 8), hold_cnt <= 0.
REQ-019 Consecutive grants SHALL therefore be separated by one idle (turnaround) cycle.
REQ-020 Simultaneous release conditions (e.g. done together with timeout) SHALL cause a single release with identical behaviour.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 Requests from non-owners during BUSY SHALL NOT affect the grant.
REQ-023 With MAX_HOLD=1, every grant SHALL last exactly one cycle.
REQ-024 hold_cnt SHALL be 4 bits and SHALL never exceed MAX_HOLD-1.

Reset
REQ-025 While rst_n=0, the block SHALL immediately and asynchronously set state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, ptr=3'd0, hold_cnt=0.
REQ-026 Reset asserted mid-grant SHALL drop gnt in the same cycle without waiting for a clock edge.
REQ-027 After rst_n deasserts, arbitration SHALL restart with requester 0 at highest priority.

Verification
REQ-028 Single requester: reset, req=8'b0000_0100 held, done=0, MAX_HOLD=4 -> the following SHALL occur:
- one cycle later gnt=8'b0000_0100, gnt_idx=2, held 4 cycles;
- then 1 cycle of gnt=0;
- then regranted to requester 2.
REQ-029 Round-robin rotation: req=8'hFF held, done pulsed on each grant's first cycle -> grant order SHALL be 0,1,2,...,7,0, with one idle cycle between grants.
REQ-030 Wrap-around: ptr=6 (after granting 5), req=8'b0000_0011 -> requester 0 SHALL be granted, then ptr SHALL be 1.
REQ-031 Owner drop: requester 3 granted, req[3] falls on the 2nd grant cycle -> gnt SHALL be 0 on the next edge and ptr SHALL be 4.
REQ-032 Async reset: during gnt=8'b1000_0000, pulse rst_n low between clock edges -> gnt=0 and gnt_valid=0 SHALL occur immediately; after release, req=8'h81 SHALL give requester 0.
REQ-033 Idle noise: done=1 with req=0 -> all outputs SHALL stay at reset values and gnt SHALL stay one-hot or zero throughout.
